// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface ctrl_sequencer_if #(
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned NUM_REG = 10,
  parameter int unsigned A_SEL_W = 4,
  parameter int unsigned ALU_W   = 3,
  parameter int unsigned CNT_W   = 16
);
  logic [OPC_W-1:0]   ir;
  logic               z_flag;
  logic               mem_ready;
  logic [A_SEL_W-1:0] a_sel;
  logic [NUM_REG-1:0] c_load;
  logic [NUM_REG-1:0] inc;
  logic [ALU_W-1:0]   alu_op;
  logic               ldir;
  logic               pc_inc;
  logic               mem_read;
  logic               mem_write;
  logic               halted;
  logic               fault;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  ir, z_flag, mem_ready,
    output a_sel, c_load, inc, alu_op, ldir, pc_inc, mem_read, mem_write,
           halted, fault, instr_cnt
  );

  modport slave (
    output ir, z_flag, mem_ready,
    input  a_sel, c_load, inc, alu_op, ldir, pc_inc, mem_read, mem_write,
           halted, fault, instr_cnt
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/execute control unit: decodes IR into datapath strobes, handles the
// memory ready handshake with timeout, and tracks halt/fault plus retired instructions.
module ctrl_sequencer #(
  parameter int unsigned OPC_W       = 6,
  parameter int unsigned NUM_REG     = 10,
  parameter int unsigned A_SEL_W     = 4,
  parameter int unsigned ALU_W       = 3,
  parameter int unsigned GP_BASE     = 4,
  parameter int unsigned ALU_SRC     = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ctrl_sequencer_if.master      bus
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned PC_IDX = 0;
  localparam int unsigned AR_IDX = 1;
  localparam int unsigned DR_IDX = 2;
  localparam int unsigned AC_IDX = 3;

  localparam logic [2:0] CLS_NOP   = 3'b000;
  localparam logic [2:0] CLS_MVAC  = 3'b001;
  localparam logic [2:0] CLS_MVR   = 3'b010;
  localparam logic [2:0] CLS_ALU   = 3'b011;
  localparam logic [2:0] CLS_INC   = 3'b100;
  localparam logic [2:0] CLS_LOAD  = 3'b101;
  localparam logic [2:0] CLS_STORE = 3'b110;

  typedef enum logic [2:0] {
    ST_RST, ST_FETCH_AR, ST_FETCH_RD, ST_EXEC, ST_MEM_WAIT, ST_HALT, ST_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [2:0]          cls;
  logic [2:0]          fld;
  logic [31:0]         gp_idx;
  logic                gp_legal;
  logic                timeout_hit;
  logic                retire;
  logic                unused_ir;

  logic [A_SEL_W-1:0]  a_sel_c;
  logic [NUM_REG-1:0]  c_load_c;
  logic [NUM_REG-1:0]  inc_c;
  logic [ALU_W-1:0]    alu_op_c;
  logic                ldir_c, pc_inc_c, mem_read_c, mem_write_c, halted_c, fault_c;

  function automatic logic [NUM_REG-1:0] onehot(input logic [31:0] idx);
    logic [NUM_REG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REG; i++) begin
      if (idx == 32'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign cls         = bus.ir[OPC_W-1 -: 3];
  assign fld         = bus.ir[2:0];
  assign gp_idx      = 32'(GP_BASE) + 32'(fld);
  assign gp_legal    = gp_idx < 32'(NUM_REG);
  assign timeout_hit = (MEM_TIMEOUT != 0) && ((32'(wait_q) + 32'd1) == 32'(MEM_TIMEOUT));
  assign unused_ir   = ^bus.ir;

  // Next state, wait/retire bookkeeping and the decoded strobes for the current state.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    a_sel_c     = '0;
    c_load_c    = '0;
    inc_c       = '0;
    alu_op_c    = '0;
    ldir_c      = 1'b0;
    pc_inc_c    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    halted_c    = 1'b0;
    fault_c     = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH_AR;

      ST_FETCH_AR: begin
        a_sel_c          = A_SEL_W'(PC_IDX);
        c_load_c[AR_IDX] = 1'b1;
        wait_d           = '0;
        state_d          = ST_FETCH_RD;
      end

      ST_FETCH_RD: begin
        mem_read_c = 1'b1;
        if (bus.mem_ready) begin
          ldir_c   = 1'b1;
          pc_inc_c = 1'b1;
          state_d  = ST_EXEC;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH_AR;
        case (cls)
          CLS_NOP: retire = 1'b1;
          CLS_MVAC: begin
            if (gp_legal) begin
              a_sel_c          = A_SEL_W'(gp_idx);
              c_load_c[AC_IDX] = 1'b1;
              retire           = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
          end
          CLS_MVR: begin
            if (gp_legal) begin
              a_sel_c  = A_SEL_W'(AC_IDX);
              c_load_c = onehot(gp_idx);
              retire   = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
          end
          CLS_ALU: begin
            a_sel_c          = A_SEL_W'(ALU_SRC);
            alu_op_c         = ALU_W'(fld);
            c_load_c[AC_IDX] = 1'b1;
            retire           = 1'b1;
          end
          CLS_INC: begin
            if (gp_legal) begin
              inc_c  = onehot(gp_idx);
              retire = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
          end
          CLS_LOAD, CLS_STORE: begin
            a_sel_c = A_SEL_W'(DR_IDX);
            wait_d  = '0;
            state_d = ST_MEM_WAIT;
          end
          default: begin
            retire = 1'b1;
            if (fld == 3'b111) begin
              state_d = ST_HALT;
            end else if (bus.z_flag) begin
              a_sel_c          = A_SEL_W'(DR_IDX);
              c_load_c[PC_IDX] = 1'b1;
            end
          end
        endcase
      end

      // Only LOAD/STORE reach here; anything not LOAD is treated as a write.
      ST_MEM_WAIT: begin
        a_sel_c     = A_SEL_W'(DR_IDX);
        mem_read_c  = (cls == CLS_LOAD);
        mem_write_c = (cls != CLS_LOAD);
        if (bus.mem_ready) begin
          c_load_c[DR_IDX] = (cls == CLS_LOAD);
          retire           = 1'b1;
          state_d          = ST_FETCH_AR;
        end else if (timeout_hit) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      ST_HALT:  halted_c = 1'b1;
      ST_FAULT: fault_c  = 1'b1;
      default:  state_d  = ST_RST;
    endcase

    cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a_sel     = a_sel_c;
  assign bus.c_load    = c_load_c;
  assign bus.inc       = inc_c;
  assign bus.alu_op    = alu_op_c;
  assign bus.ldir      = ldir_c;
  assign bus.pc_inc    = pc_inc_c;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_write = mem_write_c;
  assign bus.halted    = halted_c;
  assign bus.fault     = fault_c;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: directed scenarios with literal expectations plus a random
// instruction/ready stream, all checked every cycle against an instruction-level model.
module tb_ctrl_sequencer;

  localparam int unsigned OPC_W       = 6;
  localparam int unsigned NUM_REG     = 10;
  localparam int unsigned A_SEL_W     = 4;
  localparam int unsigned ALU_W       = 3;
  localparam int unsigned GP_BASE     = 4;
  localparam int unsigned ALU_SRC     = 4;
  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 4;

  // Where the model is within an instruction's life.
  localparam int PH_IDLE = 0, PH_ADDR = 1, PH_READ = 2, PH_EXEC = 3, PH_MEM = 4,
                 PH_HALT = 5, PH_FAULT = 6;

  typedef struct {
    int a_sel; int c_load; int inc; int alu;
    bit ldir; bit pc_inc; bit rd; bit wr; bit halted; bit fault;
    int nphase; int nwait; int ncnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   m_ph = 0, m_w = 0, m_cnt = 0;
  exp_t cur, nxt;

  ctrl_sequencer_if #(.OPC_W(OPC_W), .NUM_REG(NUM_REG), .A_SEL_W(A_SEL_W),
                      .ALU_W(ALU_W), .CNT_W(CNT_W)) bus ();

  ctrl_sequencer #(
    .OPC_W(OPC_W), .NUM_REG(NUM_REG), .A_SEL_W(A_SEL_W), .ALU_W(ALU_W),
    .GP_BASE(GP_BASE), .ALU_SRC(ALU_SRC), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction semantics: what each phase drives and where the instruction goes next.
  function automatic exp_t model(int ph, int w, int cnt, int irv, bit z, bit rdy);
    exp_t e;
    int   cls, f, r;
    bit   ok, retire;
    e = '{default: 0};
    cls = (irv >> 3) & 7;
    f = irv & 7;
    r = GP_BASE + f;
    ok = (r < NUM_REG);
    retire = 1'b0;
    e.nphase = ph;
    e.nwait = w;
    case (ph)
      PH_IDLE: e.nphase = PH_ADDR;
      PH_ADDR: begin e.c_load = 1 << 1; e.nphase = PH_READ; e.nwait = 0; end
      PH_READ: begin
        e.rd = 1'b1;
        if (rdy) begin e.ldir = 1'b1; e.pc_inc = 1'b1; e.nphase = PH_EXEC; end
        else begin e.nwait = w + 1; if (e.nwait == MEM_TIMEOUT) e.nphase = PH_FAULT; end
      end
      PH_EXEC: begin
        e.nphase = PH_ADDR;
        if (cls == 0) retire = 1'b1;
        else if (cls == 1 || cls == 2 || cls == 4) begin
          if (!ok) e.nphase = PH_FAULT;
          else begin
            retire = 1'b1;
            if (cls == 1) begin e.a_sel = r; e.c_load = 1 << 3; end
            else if (cls == 2) begin e.a_sel = 3; e.c_load = 1 << r; end
            else e.inc = 1 << r;
          end
        end
        else if (cls == 3) begin e.a_sel = ALU_SRC; e.alu = f; e.c_load = 1 << 3; retire = 1'b1; end
        else if (cls == 5 || cls == 6) begin e.a_sel = 2; e.nphase = PH_MEM; e.nwait = 0; end
        else begin
          retire = 1'b1;
          if (f == 7) e.nphase = PH_HALT;
          else if (z) begin e.a_sel = 2; e.c_load = 1; end
        end
      end
      PH_MEM: begin
        e.a_sel = 2;
        if (cls == 5) e.rd = 1'b1; else e.wr = 1'b1;
        if (rdy) begin
          if (cls == 5) e.c_load = 1 << 2;
          retire = 1'b1;
          e.nphase = PH_ADDR;
        end else begin e.nwait = w + 1; if (e.nwait == MEM_TIMEOUT) e.nphase = PH_FAULT; end
      end
      PH_HALT:  e.halted = 1'b1;
      default:  e.fault = 1'b1;
    endcase
    e.ncnt = retire ? ((cnt + 1) % (1 << CNT_W)) : cnt;
    return e;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    cur = model(m_ph, m_w, m_cnt, int'(bus.ir), bus.z_flag, bus.mem_ready);
    chk("a_sel", 32'(bus.a_sel), cur.a_sel);
    chk("c_load", 32'(bus.c_load), cur.c_load);
    chk("inc", 32'(bus.inc), cur.inc);
    chk("alu_op", 32'(bus.alu_op), cur.alu);
    chk("ldir", 32'(bus.ldir), 32'(cur.ldir));
    chk("pc_inc", 32'(bus.pc_inc), 32'(cur.pc_inc));
    chk("mem_read", 32'(bus.mem_read), 32'(cur.rd));
    chk("mem_write", 32'(bus.mem_write), 32'(cur.wr));
    chk("halted", 32'(bus.halted), 32'(cur.halted));
    chk("fault", 32'(bus.fault), 32'(cur.fault));
    chk("instr_cnt", 32'(bus.instr_cnt), m_cnt);
    nxt = cur;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = PH_IDLE; m_w = 0; m_cnt = 0;
    end else begin
      m_ph = nxt.nphase; m_w = nxt.nwait; m_cnt = nxt.ncnt;
    end
  end

  initial begin
    int hold;
    int drought;
    rst_n = 1'b0;
    bus.ir = 6'b001_001;
    bus.z_flag = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_c_load", 32'(bus.c_load), 32'h0);
    chk("rst_cnt", 32'(bus.instr_cnt), 32'h0);

    // MVAC R1 with memory always ready
    step(); rst_n = 1'b1;
    step(); @(negedge clk);
    chk("t1_c1_c_load", 32'(bus.c_load), 32'h002);
    chk("t1_c1_a_sel", 32'(bus.a_sel), 32'h0);
    step(); @(negedge clk);
    chk("t1_c2_rd", 32'(bus.mem_read), 32'h1);
    chk("t1_c2_ldir", 32'(bus.ldir), 32'h1);
    chk("t1_c2_pcinc", 32'(bus.pc_inc), 32'h1);
    step(); @(negedge clk);
    chk("t1_c3_a_sel", 32'(bus.a_sel), 32'h5);
    chk("t1_c3_c_load", 32'(bus.c_load), 32'h008);
    step(); bus.ir = 6'b101_000; @(negedge clk);
    chk("t1_cnt", 32'(bus.instr_cnt), 32'h1);

    // LOAD with three not-ready cycles in the memory wait
    step(); step(); bus.mem_ready = 1'b0; @(negedge clk);
    chk("t2_exec_a_sel", 32'(bus.a_sel), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step(); @(negedge clk);
      chk("t2_wait_rd", 32'(bus.mem_read), 32'h1);
      chk("t2_wait_c_load", 32'(bus.c_load), 32'h0);
      chk("t2_wait_wr", 32'(bus.mem_write), 32'h0);
    end
    step(); bus.mem_ready = 1'b1; @(negedge clk);
    chk("t2_ready_c_load", 32'(bus.c_load), 32'h004);
    chk("t2_ready_wr", 32'(bus.mem_write), 32'h0);
    step(); bus.ir = 6'b111_000; bus.z_flag = 1'b1; @(negedge clk);
    chk("t2_cnt", 32'(bus.instr_cnt), 32'h2);

    // JPZ taken, then not taken
    step(); step(); @(negedge clk);
    chk("t3_jpz1_c_load", 32'(bus.c_load), 32'h001);
    chk("t3_jpz1_a_sel", 32'(bus.a_sel), 32'h2);
    step(); bus.z_flag = 1'b0;
    step(); step(); @(negedge clk);
    chk("t3_jpz0_c_load", 32'(bus.c_load), 32'h000);
    step(); bus.mem_ready = 1'b0; bus.ir = 6'b000_000; @(negedge clk);
    chk("t3_cnt", 32'(bus.instr_cnt), 32'h4);

    // Fetch read timeout
    step();
    for (int i = 0; i < 15; i++) begin
      step(); @(negedge clk);
      chk("t4_no_fault_yet", 32'(bus.fault), 32'h0);
    end
    step(); @(negedge clk);
    chk("t4_fault", 32'(bus.fault), 32'h1);
    chk("t4_cnt_kept", 32'(bus.instr_cnt), 32'h4);
    step(); bus.mem_ready = 1'b1;
    step(); @(negedge clk);
    chk("t4_fault_sticky", 32'(bus.fault), 32'h1);
    chk("t4_fault_no_rd", 32'(bus.mem_read), 32'h0);
    step(); rst_n = 1'b0; #1;
    chk("t4_rst_fault", 32'(bus.fault), 32'h0);
    chk("t4_rst_cnt", 32'(bus.instr_cnt), 32'h0);
    step(); rst_n = 1'b1; bus.ir = 6'b100_111;

    // Illegal INC register, then HALT
    step(); step(); step(); @(negedge clk);
    chk("t5_inc_none", 32'(bus.inc), 32'h0);
    step(); @(negedge clk);
    chk("t5_fault", 32'(bus.fault), 32'h1);
    chk("t5_cnt0", 32'(bus.instr_cnt), 32'h0);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; bus.ir = 6'b111_111;
    repeat (4) step();
    @(negedge clk);
    chk("t5_halted", 32'(bus.halted), 32'h1);
    chk("t5_halt_cnt", 32'(bus.instr_cnt), 32'h1);
    step(); @(negedge clk);
    chk("t5_halt_sticky", 32'(bus.halted), 32'h1);

    // Async reset in the middle of a memory wait, then counter wrap
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; bus.ir = 6'b101_000;
    step(); step(); step(); bus.mem_ready = 1'b0;
    step(); @(negedge clk);
    chk("t6_in_wait_rd", 32'(bus.mem_read), 32'h1);
    @(posedge clk); #3 rst_n = 1'b0; #1;
    chk("t6_async_rd", 32'(bus.mem_read), 32'h0);
    chk("t6_async_a_sel", 32'(bus.a_sel), 32'h0);
    chk("t6_async_cnt", 32'(bus.instr_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; bus.ir = 6'b000_000; bus.mem_ready = 1'b1;
    repeat (52) step();
    @(negedge clk);
    chk("t6_wrap_cnt", 32'(bus.instr_cnt), 32'h1);

    // Random instruction and handshake stream
    hold = 0;
    drought = 0;
    for (int n = 0; n < 2500; n++) begin
      step();
      if (m_ph == PH_HALT || m_ph == PH_FAULT) begin
        hold++;
        if (hold > 3) begin
          hold = 0;
          rst_n = 1'b0;
          step();
          rst_n = 1'b1;
        end
      end
      if (m_ph == PH_ADDR || m_ph == PH_IDLE) bus.ir = 6'($urandom_range(63, 0));
      if (drought > 0) begin
        bus.mem_ready = 1'b0;
        drought--;
      end else begin
        if ($urandom_range(39, 0) == 0) drought = 20;
        bus.mem_ready = ($urandom_range(3, 0) != 0);
      end
      bus.z_flag = 1'($urandom_range(1, 0));
    end
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
